// File: rtl/ual_sequencer.sv
// ual_sequencer: microprogram sequencer driving the UAL/accumulator/carry
// datapath strobes from a small internal instruction memory.
// Opcodes in bits [7:6]: 00 EXEC, 01 INITC, 10 JC, 11 HALT.
module ual_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              carry,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              init_carry,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_d;
  logic              hazard_q;
  logic              hazard_d;
  logic              err_d;
  logic              done_d;
  logic [2:0]        sel_d;
  logic              load_r1_d;
  logic              load_accu_d;
  logic              load_carry_d;
  logic              init_carry_d;
  logic              advance;

  logic [7:0]        mem [PROG_DEPTH];
  logic [7:0]        instr;

  // Asynchronous read of the word currently being decoded.
  assign instr = mem[pc];
  assign busy  = (state_q == RUN);

  // Instruction memory is only writable while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && state_q == IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Decode the current word and work out the next state, pc and strobes.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    hazard_d     = hazard_q;
    err_d        = err;
    done_d       = 1'b0;
    sel_d        = 3'd0;
    load_r1_d    = 1'b0;
    load_accu_d  = 1'b0;
    load_carry_d = 1'b0;
    init_carry_d = 1'b0;
    advance      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ce && start) begin
          state_d  = RUN;
          pc_d     = '0;
          err_d    = 1'b0;
          hazard_d = 1'b0;
        end
      end

      RUN: begin
        if (ce) begin
          case (instr[7:6])
            2'b00: begin
              sel_d        = instr[2:0];
              load_r1_d    = instr[3];
              load_accu_d  = instr[4];
              load_carry_d = instr[5];
              hazard_d     = instr[5];
              advance      = 1'b1;
            end
            2'b01: begin
              init_carry_d = 1'b1;
              hazard_d     = 1'b1;
              advance      = 1'b1;
            end
            2'b10: begin
              // Carry is stale right after a carry update: spend one bubble
              // cycle and evaluate the same JC again on the next cycle.
              hazard_d = 1'b0;
              if (!hazard_q) begin
                if (carry) begin
                  pc_d = instr[ADDR_W-1:0];
                end else begin
                  advance = 1'b1;
                end
              end
            end
            default: begin
              state_d  = IDLE;
              done_d   = 1'b1;
              hazard_d = 1'b0;
            end
          endcase

          // Falling off the last address ends the program with an error.
          if (advance) begin
            if (pc == LAST_ADDR) begin
              state_d  = IDLE;
              done_d   = 1'b1;
              err_d    = 1'b1;
              hazard_d = 1'b0;
            end else begin
              pc_d = pc + ADDR_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pc and registered strobes; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc         <= '0;
      hazard_q   <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      sel_UAL    <= 3'd0;
      load_R1    <= 1'b0;
      load_accu  <= 1'b0;
      load_carry <= 1'b0;
      init_carry <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      hazard_q   <= hazard_d;
      err        <= err_d;
      done       <= done_d;
      sel_UAL    <= sel_d;
      load_R1    <= load_r1_d;
      load_accu  <= load_accu_d;
      load_carry <= load_carry_d;
      init_carry <= init_carry_d;
    end
  end

endmodule

// File: tb/tb_ual_sequencer.sv
// tb_ual_sequencer: directed scenarios for ual_sequencer with hand-computed
// expectations of the output vector and pc, cycle by cycle.
module tb_ual_sequencer;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       start;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       carry;
  logic [2:0] sel_UAL;
  logic       load_R1;
  logic       load_accu;
  logic       load_carry;
  logic       init_carry;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] pc;

  int errors = 0;
  int checks = 0;

  ual_sequencer #(.PROG_DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .carry      (carry),
    .sel_UAL    (sel_UAL),
    .load_R1    (load_R1),
    .load_accu  (load_accu),
    .load_carry (load_carry),
    .init_carry (init_carry),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc         (pc)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {sel[2:0], load_R1, load_accu, load_carry, init_carry, busy, done, err}
  function automatic logic [9:0] outs();
    return {sel_UAL, load_R1, load_accu, load_carry, init_carry, busy, done, err};
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] addr, input logic [7:0] data);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  // Pulse start for one edge; on return we are in cycle t+1.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ce        = 1'($urandom);
      start     = 1'($urandom);
      prog_we   = 1'($urandom);
      prog_addr = 4'($urandom);
      prog_data = 8'($urandom);
      carry     = 1'($urandom);
      tick();
      checks++;
      if (outs() !== 10'd0) begin
        errors++;
        $display("[TB] FAIL reset_outs cycle %0d got=%b exp=%b", i, outs(), 10'd0);
      end
      checks++;
      if (pc !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_pc cycle %0d got=%0d exp=0", i, pc);
      end
    end
    rst = 1'b0; ce = 1'b1; start = 1'b0; prog_we = 1'b0; carry = 1'b0;
    prog_addr = 4'd0; prog_data = 8'd0;
    tick();
  endtask

  task automatic test_exec_halt();
    write_word(4'd0, 8'h13);
    write_word(4'd1, 8'hC0);
    pulse_start();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b100}) begin
      errors++;
      $display("[TB] FAIL exec_t1 got=%b exp=%b", outs(), {3'd0, 4'b0000, 3'b100});
    end
    tick();
    checks++;
    if (outs() !== {3'd3, 4'b0100, 3'b100}) begin
      errors++;
      $display("[TB] FAIL exec_t2 got=%b exp=%b", outs(), {3'd3, 4'b0100, 3'b100});
    end
    tick();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b010}) begin
      errors++;
      $display("[TB] FAIL exec_t3_done got=%b exp=%b", outs(), {3'd0, 4'b0000, 3'b010});
    end
    checks++;
    if (pc !== 4'd1) begin
      errors++;
      $display("[TB] FAIL exec_halt_pc got=%0d exp=1", pc);
    end
    tick();
    checks++;
    if (outs() !== 10'd0) begin
      errors++;
      $display("[TB] FAIL exec_t4_idle got=%b exp=%b", outs(), 10'd0);
    end
  endtask

  task automatic test_jc_hazard(input logic take);
    logic [3:0] tgt;
    tgt = take ? 4'd5 : 4'd2;
    carry = 1'b0;
    write_word(4'd0, 8'h40);
    write_word(4'd1, 8'h85);
    write_word(4'd2, 8'hC0);
    write_word(4'd5, 8'hC0);
    pulse_start();
    tick();
    checks++;
    if (outs() !== {3'd0, 4'b0001, 3'b100} || pc !== 4'd1) begin
      errors++;
      $display("[TB] FAIL jc%0b_initc got=%b pc=%0d exp=%b pc=1", take, outs(), pc,
               {3'd0, 4'b0001, 3'b100});
    end
    tick();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b100} || pc !== 4'd1) begin
      errors++;
      $display("[TB] FAIL jc%0b_bubble got=%b pc=%0d exp=%b pc=1", take, outs(), pc,
               {3'd0, 4'b0000, 3'b100});
    end
    carry = take;
    tick();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b100} || pc !== tgt) begin
      errors++;
      $display("[TB] FAIL jc%0b_target got=%b pc=%0d exp=%b pc=%0d", take, outs(), pc,
               {3'd0, 4'b0000, 3'b100}, tgt);
    end
    tick();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b010} || pc !== tgt) begin
      errors++;
      $display("[TB] FAIL jc%0b_done got=%b pc=%0d exp=%b pc=%0d", take, outs(), pc,
               {3'd0, 4'b0000, 3'b010}, tgt);
    end
    carry = 1'b0;
    tick();
  endtask

  task automatic test_ce_freeze();
    write_word(4'd0, 8'h01);
    write_word(4'd1, 8'h0A);
    write_word(4'd2, 8'h23);
    write_word(4'd3, 8'hC0);
    pulse_start();
    tick();
    checks++;
    if (outs() !== {3'd1, 4'b0000, 3'b100} || pc !== 4'd1) begin
      errors++;
      $display("[TB] FAIL ce_first got=%b pc=%0d exp=%b pc=1", outs(), pc, {3'd1, 4'b0000, 3'b100});
    end
    tick();
    checks++;
    if (outs() !== {3'd2, 4'b1000, 3'b100} || pc !== 4'd2) begin
      errors++;
      $display("[TB] FAIL ce_second got=%b pc=%0d exp=%b pc=2", outs(), pc, {3'd2, 4'b1000, 3'b100});
    end
    ce        = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 4'd3;
    prog_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      tick();
      prog_we = 1'b0;
      checks++;
      if (outs() !== {3'd0, 4'b0000, 3'b100} || pc !== 4'd2) begin
        errors++;
        $display("[TB] FAIL ce_frozen%0d got=%b pc=%0d exp=%b pc=2", i, outs(), pc,
                 {3'd0, 4'b0000, 3'b100});
      end
    end
    ce = 1'b1;
    tick();
    checks++;
    if (outs() !== {3'd3, 4'b0010, 3'b100} || pc !== 4'd3) begin
      errors++;
      $display("[TB] FAIL ce_resume got=%b pc=%0d exp=%b pc=3", outs(), pc, {3'd3, 4'b0010, 3'b100});
    end
    tick();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b010} || pc !== 4'd3) begin
      errors++;
      $display("[TB] FAIL ce_busy_write_ignored got=%b pc=%0d exp=%b pc=3", outs(), pc,
               {3'd0, 4'b0000, 3'b010});
    end
    tick();
  endtask

  task automatic test_runoff();
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 8'h10 | 8'(i % 8));
    end
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      logic [2:0] s;
      logic [2:0] f;
      s = 3'(i % 8);
      f = (i == 15) ? 3'b011 : 3'b100;
      tick();
      checks++;
      if (outs() !== {s, 4'b0100, f}) begin
        errors++;
        $display("[TB] FAIL runoff_strobe%0d got=%b exp=%b", i, outs(), {s, 4'b0100, f});
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs() !== {3'd0, 4'b0000, 3'b001}) begin
        errors++;
        $display("[TB] FAIL runoff_err_hold%0d got=%b exp=%b", i, outs(), {3'd0, 4'b0000, 3'b001});
      end
    end
    pulse_start();
    checks++;
    if (outs() !== {3'd0, 4'b0000, 3'b100} || pc !== 4'd0) begin
      errors++;
      $display("[TB] FAIL restart_err_clear got=%b pc=%0d exp=%b pc=0", outs(), pc,
               {3'd0, 4'b0000, 3'b100});
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (outs() !== 10'd0 || pc !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midrun_reset got=%b pc=%0d exp=%b pc=0", outs(), pc, 10'd0);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_reset_stays_idle got=%0b exp=0", busy);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = 4'd0; prog_data = 8'd0; carry = 1'b0;
    test_reset();
    test_exec_halt();
    test_jc_hazard(1'b1);
    test_jc_hazard(1'b0);
    test_ce_freeze();
    test_runoff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
